branch_resolve_bht: RTL

Parametrised branch prediction and resolution unit for the QingFeng core. It predicts taken/not-taken and the target in IF from a direct-mapped BTB with 2-bit saturating counters. It resolves B-type, jal and jalr in EX, and raises redirect/flush when the prediction was wrong. It also trains the table and keeps saturating branch and mispredict counters for performance analysis.

---
 rtl/branch_resolve_bht_pkg.sv | 24 ++
 rtl/branch_resolve_bht_entry_ctr.sv | 33 +++
 rtl/branch_resolve_bht.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/branch_resolve_bht_pkg.sv
// Shared encodings for the QingFeng branch predictor/resolver: control-transfer
// kinds, branch funct3 values and 2-bit counter states.
package branch_resolve_bht_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // opcode_j = opcode[3:2]; bit 0 marks a jump, bit 1 selects jal over jalr
  localparam logic [1:0] OPJ_B    = 2'b00;
  localparam logic [1:0] OPJ_JALR = 2'b01;
  localparam logic [1:0] OPJ_JAL  = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_resolve_bht_entry_ctr.sv
// Per-entry 2-bit saturating predictor counter with load, increment and decrement.
module bht_entry_ctr
  import branch_resolve_bht_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  ctr_e load_val_i,
  input  logic inc_i,
  input  logic dec_i,
  output ctr_e ctr_o
);

  ctr_e ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (load_i)
      ctr_d = load_val_i;
    else if (inc_i && ctr_q != ST)
      ctr_d = ctr_e'(ctr_q + 2'd1);
    else if (dec_i && ctr_q != SNT)
      ctr_d = ctr_e'(ctr_q - 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) ctr_q <= WNT;
    else     ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_resolve_bht.sv
// Direct-mapped BTB/BHT: combinational IF lookup, EX resolution with redirect,
// table training and saturating performance counters.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_if,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ctrl_branch,
  input  logic [1:0]       opcode_j,
  input  logic [2:0]       funct3,
  input  logic [1:0]       comp_result,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic [XLEN-1:0]  imme,
  input  logic [XLEN-1:0]  rs1,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_addr,
  output logic             flush,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [XLEN-1:0]  tgt_q   [DEPTH];
  ctr_e             ctr     [DEPTH];
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // IF lookup
  logic [IDX_W-1:0] if_idx;
  logic             if_hit;
  assign if_idx      = pc_if[IDX_W+1:2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == pc_if[XLEN-1:IDX_W+2]);
  assign pred_taken  = if_hit && ctr[if_idx][1];
  assign pred_target = if_hit ? tgt_q[if_idx] : pc_if + XLEN'(4);

  // EX resolution
  logic             active, is_jump, is_jal, legal, act_taken, ex_hit;
  logic [XLEN-1:0]  act_target;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;

  assign active  = ex_valid && ctrl_branch;
  assign is_jump = opcode_j[0];
  assign is_jal  = opcode_j[1];
  assign legal   = is_jump || (funct3 != 3'b010 && funct3 != 3'b011);
  assign ex_idx  = pc_ex[IDX_W+1:2];
  assign ex_tag  = pc_ex[XLEN-1:IDX_W+2];
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    act_taken = 1'b0;
    if (is_jump) act_taken = 1'b1;
    else begin
      case (funct3)
        F3_BEQ:           act_taken = comp_result[0];
        F3_BNE:           act_taken = !comp_result[0];
        F3_BLT, F3_BLTU:  act_taken = comp_result[1];
        F3_BGE, F3_BGEU:  act_taken = !comp_result[1];
        default:          act_taken = 1'b0;
      endcase
    end
  end

  assign act_target = (is_jump && !is_jal) ? ((rs1 + imme) & ~XLEN'(1)) : pc_ex + imme;

  assign redirect = active && ((act_taken != ex_pred_taken) ||
                               (act_taken && ex_pred_taken && act_target != ex_pred_target));
  assign redirect_addr = act_taken ? act_target : pc_ex + XLEN'(4);
  assign flush         = redirect;

  // Training controls
  logic upd, wr_entry, ctr_load, ctr_inc, ctr_dec;
  ctr_e ctr_load_val;
  assign upd          = active && legal;
  assign wr_entry     = upd && (is_jump || act_taken);
  assign ctr_load     = upd && (is_jump || (!ex_hit && act_taken));
  assign ctr_load_val = is_jump ? ST : WT;
  assign ctr_inc      = upd && !is_jump && ex_hit && act_taken;
  assign ctr_dec      = upd && !is_jump && ex_hit && !act_taken;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
    logic sel;
    assign sel = (ex_idx == IDX_W'(g));
    bht_entry_ctr u_ctr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ctr_load && sel),
      .load_val_i (ctr_load_val),
      .inc_i      (ctr_inc && sel),
      .dec_i      (ctr_dec && sel),
      .ctr_o      (ctr[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (wr_entry) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_tag;
      tgt_q[ex_idx]   <= act_target;
    end
  end

  // Performance counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (upd)      br_cnt_q  <= sat_inc(br_cnt_q);
      if (redirect) mis_cnt_q <= sat_inc(mis_cnt_q);
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;

endmodule
